// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: start/length request plus buffer strobes and array valids of the systolic controller
interface systolic_ctrl_if #(
    parameter int ARRAY_DIM = 4,
    parameter int LEN_W     = 8
);
    localparam int AW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    logic                 start;
    logic [LEN_W-1:0]     cfg_len;
    logic                 w_rd_en;
    logic [AW-1:0]        w_rd_addr;
    logic                 ifmap_rd_en;
    logic [LEN_W-1:0]     ifmap_rd_addr;
    logic [ARRAY_DIM-1:0] row_valid;
    logic [ARRAY_DIM-1:0] col_valid;
    logic                 busy;
    logic                 done;
    modport master (
        output start, cfg_len,
        input  w_rd_en, w_rd_addr, ifmap_rd_en, ifmap_rd_addr, row_valid, col_valid, busy, done
    );
    modport slave (
        input  start, cfg_len,
        output w_rd_en, w_rd_addr, ifmap_rd_en, ifmap_rd_addr, row_valid, col_valid, busy, done
    );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, ifmap streaming and result drain for a square MAC array
module systolic_ctrl #(
    parameter int ARRAY_DIM = 4,
    parameter int LEN_W     = 8
) (
    input logic           clk,
    input logic           rstn,
    systolic_ctrl_if.slave bus
);
    localparam int AW    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int DW    = 2 * ARRAY_DIM + 1;
    localparam int DC_W  = $clog2(DW + 1);
    localparam int CNT_W = (LEN_W > DC_W) ? LEN_W : DC_W;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [DW-1:0]    r_dly;
    logic             w_wen;
    logic             w_ien;
    logic             w_done;
    // state register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    // next-state and strobe decode; counter terminal values end each phase
    always_comb begin
        w_next = r_state;
        w_wen  = 1'b0;
        w_ien  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = (bus.cfg_len != '0) ? S_LOAD_W : S_DONE;
            S_LOAD_W: begin
                w_wen = 1'b1;
                if (r_cnt == CNT_W'(ARRAY_DIM - 1)) w_next = S_STREAM;
            end
            S_STREAM: begin
                w_ien = 1'b1;
                if (r_cnt == CNT_W'(r_len - 1'b1)) w_next = S_DRAIN;
            end
            S_DRAIN:  if (r_cnt == CNT_W'(2 * ARRAY_DIM)) w_next = S_DONE;
            S_DONE:   begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end
    // phase counter restarts at every state change, latched length, and the valid delay line
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_len <= '0;
            r_dly <= '0;
        end else begin
            r_cnt <= (w_next != r_state || r_state == S_IDLE || r_state == S_DONE) ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE && bus.start) r_len <= bus.cfg_len;
            r_dly <= {r_dly[DW-2:0], w_ien};
        end
    end
    assign bus.w_rd_en       = w_wen;
    assign bus.w_rd_addr     = w_wen ? r_cnt[AW-1:0] : '0;
    assign bus.ifmap_rd_en   = w_ien;
    assign bus.ifmap_rd_addr = w_ien ? r_cnt[LEN_W-1:0] : '0;
    assign bus.row_valid     = r_dly[ARRAY_DIM-1:0];
    assign bus.col_valid     = r_dly[DW-1:ARRAY_DIM+1];
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = w_done;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench; expected per-cycle output records queued at start, monitor compares on activity
module tb_systolic_ctrl;
    localparam int D = 4;
    localparam int L_W = 8;
    typedef struct {
        int         cyc;
        logic       done;
        logic       wen;
        int         waddr;
        logic       ien;
        int         iaddr;
        logic [D-1:0] row;
        logic [D-1:0] col;
    } exp_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    systolic_ctrl_if #(.ARRAY_DIM(D), .LEN_W(L_W)) bus ();
    systolic_ctrl #(.ARRAY_DIM(D), .LEN_W(L_W)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int tlen(input int l);
        return (l == 0) ? 1 : 3 * D + l + 2;
    endfunction
    function automatic logic ien_at(input int l, input int t);
        return (l > 0) && (t >= D + 1) && (t <= D + l);
    endfunction
    // queue the records for cycles c0+1 .. c0+n of a tile of length l accepted in cycle c0
    task automatic push_tile(input int c0, input int l, input int n);
        for (int t = 1; t <= n; t++) begin
            exp_t e;
            e.cyc   = c0 + t;
            e.done  = (t == tlen(l));
            e.wen   = (l > 0) && (t <= D);
            e.waddr = t - 1;
            e.ien   = ien_at(l, t);
            e.iaddr = t - D - 1;
            for (int i = 0; i < D; i++) begin
                e.row[i] = ien_at(l, t - i - 1);
                e.col[i] = ien_at(l, t - D - 2 - i);
            end
            sb.push_back(e);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic run(input int l);
        push_tile(cyc, l, tlen(l));
        bus.start = 1'b1;
        bus.cfg_len = L_W'(l);
        tick(1);
        bus.start = 1'b0;
        bus.cfg_len = '0;
        tick(tlen(l));
    endtask
    task automatic chk_quiet(input string name);
        n_vec++;
        if (bus.busy || bus.done || bus.w_rd_en || bus.ifmap_rd_en || bus.row_valid != 0 || bus.col_valid != 0 ||
            bus.w_rd_addr != 0 || bus.ifmap_rd_addr != 0) begin
            n_err++;
            $display("FAIL %s: got busy=%b done=%b wen=%b ien=%b waddr=%0d iaddr=%0d row=%b col=%b, want all 0",
                     name, bus.busy, bus.done, bus.w_rd_en, bus.ifmap_rd_en, bus.w_rd_addr, bus.ifmap_rd_addr,
                     bus.row_valid, bus.col_valid);
        end
    endtask
    always @(negedge clk) begin
        if (mon_en && (bus.busy || bus.done || bus.w_rd_en || bus.ifmap_rd_en || bus.row_valid != 0 || bus.col_valid != 0)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_activity cyc=%0d: got busy=%b done=%b wen=%b ien=%b row=%b col=%b, want idle",
                         cyc, bus.busy, bus.done, bus.w_rd_en, bus.ifmap_rd_en, bus.row_valid, bus.col_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || !bus.busy || bus.done != e.done || bus.w_rd_en != e.wen || bus.ifmap_rd_en != e.ien ||
                    bus.row_valid != e.row || bus.col_valid != e.col ||
                    (e.wen && int'(bus.w_rd_addr) != e.waddr) || (e.ien && int'(bus.ifmap_rd_addr) != e.iaddr)) begin
                    n_err++;
                    $display("FAIL tile_cycle: got cyc=%0d busy=%b done=%b wen=%b/%0d ien=%b/%0d row=%b col=%b; want cyc=%0d busy=1 done=%b wen=%b/%0d ien=%b/%0d row=%b col=%b",
                             cyc, bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.ifmap_rd_en, bus.ifmap_rd_addr,
                             bus.row_valid, bus.col_valid, e.cyc, e.done, e.wen, e.waddr, e.ien, e.iaddr, e.row, e.col);
                end
            end
        end
    end
    initial begin
        int c;
        bus.start = 1'b0;
        bus.cfg_len = '0;
        tick(3);
        rstn = 1'b1;
        chk_quiet("reset_state");
        mon_en = 1'b1;
        tick(2);
        run(3);
        run(0);
        run(1);
        // start re-pulsed with another length during STREAM must not disturb the tile
        c = cyc;
        push_tile(c, 3, tlen(3));
        bus.start = 1'b1;
        bus.cfg_len = 8'd3;
        tick(1);
        bus.start = 1'b0;
        tick(5);
        bus.start = 1'b1;
        bus.cfg_len = 8'd7;
        tick(1);
        bus.start = 1'b0;
        bus.cfg_len = '0;
        tick(11);
        // one-cycle reset in the middle of DRAIN aborts the tile
        c = cyc;
        push_tile(c, 3, 10);
        bus.start = 1'b1;
        bus.cfg_len = 8'd3;
        tick(1);
        bus.start = 1'b0;
        bus.cfg_len = '0;
        tick(9);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk_quiet("after_mid_reset");
        tick(1);
        run(2);
        run(255);
        // start held high: second tile accepted in the first IDLE cycle after DONE
        c = cyc;
        push_tile(c, 2, tlen(2));
        push_tile(c + tlen(2) + 1, 2, tlen(2));
        bus.start = 1'b1;
        bus.cfg_len = 8'd2;
        tick(2 * tlen(2) + 1);
        bus.start = 1'b0;
        bus.cfg_len = '0;
        tick(4);
        chk_quiet("final_idle");
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drained: got %0d pending records, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have parameter ARRAY_DIM, default 4: rows/columns of the square MAC array it sequences.
REQ-002 The block SHALL have parameter LEN_W, default 8: width of the stream-length field.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1: one-cycle request to run a tile; sampled only in IDLE.
REQ-006 The block SHALL have port cfg_len, input, LEN_W: number of ifmap vectors to stream; latched when start is accepted.
REQ-007 The block SHALL have port w_rd_en, output, 1: weight-buffer read strobe.
REQ-008 The block SHALL have port w_rd_addr, output, clog2(ARRAY_DIM): weight row address.
REQ-009 The block SHALL have port ifmap_rd_en, output, 1: ifmap-buffer read strobe.
REQ-010 The block SHALL have port ifmap_rd_addr, output, LEN_W: ifmap vector address.
REQ-011 The block SHALL have port row_valid, output, ARRAY_DIM: skewed per-row input-valid to the array edge.
REQ-012 The block SHALL have port col_valid, output, ARRAY_DIM: skewed per-column result-valid at the array bottom (ofmap write enable).
REQ-013 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN, DONE, encoded in one registered state variable.
REQ-016 In IDLE with start=1 and cfg_len!=0, the FSM SHALL latch cfg_len and enter LOAD_W on the next edge.
REQ-017 In IDLE with start=1 and cfg_len==0, the FSM SHALL enter DONE directly; no read strobe or valid is ever asserted.
REQ-018 LOAD_W SHALL last exactly ARRAY_DIM cycles, with w_rd_en=1 and w_rd_addr counting 0..ARRAY_DIM-1, then go to STREAM.
REQ-019 STREAM SHALL last exactly the latched cfg_len cycles, with ifmap_rd_en=1 and ifmap_rd_addr counting 0..len-1, then go to DRAIN.
REQ-020 row_valid[i] SHALL equal ifmap_rd_en delayed by i+1 cycles, for i=0..ARRAY_DIM-1, via a shift register.
REQ-021 col_valid[j] SHALL equal ifmap_rd_en delayed by ARRAY_DIM+2+j cycles: 1 buffer read, 1 input register, ARRAY_DIM accumulator stages, j skew.
REQ-022 DRAIN SHALL last exactly 2*ARRAY_DIM+1 cycles, so that the last col_valid[ARRAY_DIM-1] pulse falls in the final DRAIN cycle; the FSM then enters DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-024 In all states other than IDLE, start SHALL be ignored, and cfg_len changes SHALL have no effect on the running tile.
REQ-025 Counters SHALL not wrap within a tile: the maximum cfg_len of 2^LEN_W-1 yields addresses 0..2^LEN_W-2.
REQ-026 w_rd_en and ifmap_rd_en SHALL never be high in the same cycle.
REQ-027 A start accepted in the same cycle that DONE returns to IDLE is not possible: DONE ignores start, and the earliest new acceptance is the first IDLE cycle.

Reset
REQ-028 When rstn=0 at a rising edge, state SHALL become IDLE, all counters and delay lines 0, and busy, done, w_rd_en, ifmap_rd_en, row_valid and col_valid all 0 from the following cycle.
REQ-029 Reset asserted mid-operation SHALL abort the tile with no done pulse, and clear all in-flight row_valid/col_valid bits.
REQ-030 The reset value of w_rd_addr and ifmap_rd_addr SHALL be 0.

Verification
REQ-031 Scenario: ARRAY_DIM=4, start at cycle 0 with cfg_len=3 -> w_rd_en cycles 1-4 (addr 0..3); ifmap_rd_en cycles 5-7 (addr 0..2); row_valid[0] 6-8, row_valid[3] 9-11; col_valid[0] 11-13, col_valid[3] 14-16; done at cycle 17; busy cycles 1-17.
REQ-032 Scenario: start with cfg_len=0 -> done=1 on the next cycle only; no strobes or valids; busy high for that one cycle.
REQ-033 Scenario: start pulsed again during STREAM with a different cfg_len -> timing identical to an undisturbed run; a single done pulse.
REQ-034 Scenario: rstn=0 for one cycle during DRAIN -> all outputs 0 on the following cycle, no done, and a subsequent start runs a normal tile.
REQ-035 Scenario: cfg_len=255 (LEN_W=8) -> 255 ifmap strobes with addr 0..254, no wrap, and done exactly 4+255+9+1 cycles after start acceptance.
REQ-036 Scenario: back-to-back starts (start held high continuously) -> the second tile's LOAD_W begins 2 cycles after the first done, and the waveform repeats identically.
